pipeline_ctrl: RTL and testbench

//  Central pipeline controller for the 5-stage core. Arbitrates per-stage stall requests into the
//  one-hot-prefix stall[5:0] vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.

---
 rtl/pipeline_ctrl_pkg.sv | 43 ++++
 rtl/pipeline_ctrl_watchdog.sv | 47 ++++
 rtl/pipeline_ctrl.sv | 138 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall vector encodings,
// exception cause codes, FSM state type and the stall priority decoder.
package pipeline_ctrl_pkg;

  // One-hot-prefix stall vectors: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  // Exception cause codes delivered by MEM.
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_RI      = 32'h0000_000a;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_EXC_PEND = 1'b1
  } ctrl_state_e;

  // The deepest requesting stage wins; everything upstream of it holds too.
  function automatic logic [5:0] stall_decode(input logic req_if, input logic req_id,
                                              input logic req_ex, input logic req_mem);
    logic [5:0] v;
    if (req_mem) begin
      v = STALL_MEM;
    end else if (req_ex) begin
      v = STALL_EX;
    end else if (req_id) begin
      v = STALL_ID;
    end else if (req_if) begin
      v = STALL_IF;
    end else begin
      v = STALL_NONE;
    end
    return v;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_watchdog.sv
// Stall watchdog: counts consecutive cycles in which the PC is held and sets
// a sticky timeout flag once the count reaches WDOG_LIMIT.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   stall_pc_i    stall_o[0] from the controller (PC held this cycle)
//   timeout_o     sticky flag, cleared only by rst
module pipeline_ctrl_watchdog #(
  parameter int unsigned WDOG_LIMIT = 1024,
  parameter int unsigned WDOG_W     = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_pc_i,
  output logic timeout_o
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(WDOG_LIMIT);

  logic [WDOG_W-1:0] cnt_q, cnt_d;
  logic              timeout_q;

  // Next count: run of held cycles, saturating at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (!stall_pc_i) begin
      cnt_d = {WDOG_W{1'b0}};
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + {{(WDOG_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and sticky flag registers; the flag sets at the edge the count reaches the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= {WDOG_W{1'b0}};
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_q | (cnt_d == LIMIT);
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central controller for the 5-stage core: stall arbitration, exception
// flush/redirect (deferred while MEM waits on the data bus), stall and flush
// statistics, and a stall watchdog.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stallreq_*_i        per-stage stall requests (IF, ID, EX, MEM)
//   excepttype_i        exception cause from MEM, 0 = none
//   cp0_epc_i           current EPC (ERET target)
//   stall_o             hold vector to the pipeline registers (combinational)
//   flush_o, new_pc_o   flush strobe and redirect target (combinational)
//   stall_timeout_o     sticky watchdog flag
//   stall_cycles_o      cycles with any stall, wrapping
//   flush_count_o       flushes issued, saturating
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int unsigned WDOG_LIMIT = 1024,
  parameter int unsigned WDOG_W     = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        stall_timeout_o,
  output logic [31:0] stall_cycles_o,
  output logic [15:0] flush_count_o
);

  ctrl_state_e state_q, state_d;
  logic [31:0] exc_q, exc_d;
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_count_q;
  logic [5:0]  stall_s;
  logic        flush_s;
  logic [31:0] cause_s;
  logic [31:0] new_pc_s;

  // Stall/flush decode and FSM next state; outputs stay quiet while rst is high.
  always_comb begin
    stall_s = STALL_NONE;
    flush_s = 1'b0;
    cause_s = 32'h0000_0000;
    state_d = state_q;
    exc_d   = exc_q;
    if (rst) begin
      state_d = ST_RUN;
      exc_d   = 32'h0000_0000;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (excepttype_i != 32'h0000_0000) begin
            if (!stallreq_mem_i) begin
              // Flush beats any stall request raised in the same cycle.
              flush_s = 1'b1;
              cause_s = excepttype_i;
            end else begin
              // MEM still owns the bus: hold it and remember the cause.
              stall_s = STALL_MEM;
              state_d = ST_EXC_PEND;
              exc_d   = excepttype_i;
            end
          end else begin
            stall_s = stall_decode(stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i);
          end
        end
        ST_EXC_PEND: begin
          if (stallreq_mem_i) begin
            stall_s = STALL_MEM;
          end else begin
            flush_s = 1'b1;
            cause_s = exc_q;
            state_d = ST_RUN;
            exc_d   = 32'h0000_0000;
          end
        end
        default: begin
          state_d = ST_RUN;
          exc_d   = 32'h0000_0000;
        end
      endcase
    end
  end

  // Redirect target: ERET returns to EPC as seen in the flush cycle.
  always_comb begin
    if (!flush_s) begin
      new_pc_s = 32'h0000_0000;
    end else if (cause_s == EXC_ERET) begin
      new_pc_s = cp0_epc_i;
    end else begin
      new_pc_s = EXC_VECTOR;
    end
  end

  // FSM state, latched cause and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      exc_q          <= 32'h0000_0000;
      stall_cycles_q <= 32'h0000_0000;
      flush_count_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
      if (stall_s != STALL_NONE) begin
        stall_cycles_q <= stall_cycles_q + 32'h0000_0001;
      end
      if (flush_s && (flush_count_q != 16'hFFFF)) begin
        flush_count_q <= flush_count_q + 16'h0001;
      end
    end
  end

  pipeline_ctrl_watchdog #(
    .WDOG_LIMIT (WDOG_LIMIT),
    .WDOG_W     (WDOG_W)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .stall_pc_i (stall_s[0]),
    .timeout_o  (stall_timeout_o)
  );

  assign stall_o        = stall_s;
  assign flush_o        = flush_s;
  assign new_pc_o       = new_pc_s;
  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        stall_timeout_o;
  logic [31:0] stall_cycles_o;
  logic [15:0] flush_count_o;

  pipeline_ctrl #(
    .EXC_VECTOR (32'h0000_0020),
    .WDOG_LIMIT (8),
    .WDOG_W     (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stallreq_if_i   (stallreq_if_i),
    .stallreq_id_i   (stallreq_id_i),
    .stallreq_ex_i   (stallreq_ex_i),
    .stallreq_mem_i  (stallreq_mem_i),
    .excepttype_i    (excepttype_i),
    .cp0_epc_i       (cp0_epc_i),
    .stall_o         (stall_o),
    .flush_o         (flush_o),
    .new_pc_o        (new_pc_o),
    .stall_timeout_o (stall_timeout_o),
    .stall_cycles_o  (stall_cycles_o),
    .flush_count_o   (flush_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [5:0] stall;
    logic       flush;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Reference model of the registered statistics and watchdog.
  logic [31:0] m_cycles = 32'h0;
  logic [15:0] m_flushes = 16'h0;
  int          m_wd = 0;
  logic        m_to = 1'b0;

  // Apply one cycle of stimulus and queue the outputs it must produce.
  task automatic drive(input logic r, input logic fi, input logic fd, input logic fe,
                       input logic fm, input logic [31:0] exc, input logic [31:0] epc,
                       input logic [5:0] es, input logic ef, input logic [31:0] epx);
    exp_t x;
    rst = r; stallreq_if_i = fi; stallreq_id_i = fd; stallreq_ex_i = fe;
    stallreq_mem_i = fm; excepttype_i = exc; cp0_epc_i = epc;
    x.rst = r; x.stall = es; x.flush = ef; x.pc = epx;
    sb_q.push_back(x);
  endtask

  // Advance the reference model across the clock edge that ends this cycle.
  task automatic model_edge(input exp_t x);
    if (x.rst) begin
      m_cycles = 32'h0; m_flushes = 16'h0; m_wd = 0; m_to = 1'b0;
    end else begin
      if (x.stall != 6'b0) m_cycles = m_cycles + 32'h1;
      if (x.flush && m_flushes != 16'hFFFF) m_flushes = m_flushes + 16'h1;
      m_wd = x.stall[0] ? ((m_wd < 8) ? m_wd + 1 : 8) : 0;
      if (m_wd == 8) m_to = 1'b1;
    end
    @(posedge clk); #1; cyc++;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8, 32'h0, 6'b0, 1'b0, 32'h0);
      @(negedge clk); e = sb_q.pop_front();
      n_cmp++; if ({stall_o, flush_o, new_pc_o} !== {e.stall, e.flush, e.pc}) begin n_err++;
        $display("FAIL reset_out cyc%0d: got %b/%b/%h want %b/%b/%h", cyc, stall_o, flush_o, new_pc_o, e.stall, e.flush, e.pc); end
      n_cmp++; if ({stall_cycles_o, flush_count_o, stall_timeout_o} !== {m_cycles, m_flushes, m_to}) begin n_err++;
        $display("FAIL reset_cnt cyc%0d: got %0d/%0d/%b want %0d/%0d/%b", cyc, stall_cycles_o, flush_count_o, stall_timeout_o, m_cycles, m_flushes, m_to); end
      model_edge(e);
    end
  endtask

  task automatic test_stall_priority();
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 6'b001111, 1'b0, 32'h0);
        1: drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h0);
        2: drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 6'b000111, 1'b0, 32'h0);
        3: drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'b000011, 1'b0, 32'h0);
        4: drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 6'b001111, 1'b0, 32'h0);
        default: drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0);
      endcase
      @(negedge clk); e = sb_q.pop_front();
      n_cmp++; if ({stall_o, flush_o, new_pc_o} !== {e.stall, e.flush, e.pc}) begin n_err++;
        $display("FAIL stall_prio cyc%0d: got %b/%b/%h want %b/%b/%h", cyc, stall_o, flush_o, new_pc_o, e.stall, e.flush, e.pc); end
      n_cmp++; if ({stall_cycles_o, flush_count_o, stall_timeout_o} !== {m_cycles, m_flushes, m_to}) begin n_err++;
        $display("FAIL stall_cnt cyc%0d: got %0d/%0d/%b want %0d/%0d/%b", cyc, stall_cycles_o, flush_count_o, stall_timeout_o, m_cycles, m_flushes, m_to); end
      model_edge(e);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 6'b0, 1'b1, 32'h20);
        1: drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'ha, 32'h0, 6'b0, 1'b1, 32'h20);
        2: drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'he, 32'h1234, 6'b0, 1'b1, 32'h1234);
        default: drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'b0, 1'b0, 32'h0);
      endcase
      @(negedge clk); e = sb_q.pop_front();
      n_cmp++; if ({stall_o, flush_o, new_pc_o} !== {e.stall, e.flush, e.pc}) begin n_err++;
        $display("FAIL flush cyc%0d: got %b/%b/%h want %b/%b/%h", cyc, stall_o, flush_o, new_pc_o, e.stall, e.flush, e.pc); end
      n_cmp++; if ({stall_cycles_o, flush_count_o, stall_timeout_o} !== {m_cycles, m_flushes, m_to}) begin n_err++;
        $display("FAIL flush_cnt cyc%0d: got %0d/%0d/%b want %0d/%0d/%b", cyc, stall_cycles_o, flush_count_o, stall_timeout_o, m_cycles, m_flushes, m_to); end
      model_edge(e);
    end
  endtask

  task automatic test_deferred_exc();
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hc, 32'h0, 6'b011111, 1'b0, 32'h0);
        1: drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h0);
        2: drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h0);
        3: drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'b000000, 1'b1, 32'h20);
        4: drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'he, 32'h1234, 6'b011111, 1'b0, 32'h0);
        5: drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h5678, 6'b000000, 1'b1, 32'h5678);
        6: drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h0);
        default: drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0);
      endcase
      @(negedge clk); e = sb_q.pop_front();
      n_cmp++; if ({stall_o, flush_o, new_pc_o} !== {e.stall, e.flush, e.pc}) begin n_err++;
        $display("FAIL deferred cyc%0d: got %b/%b/%h want %b/%b/%h", cyc, stall_o, flush_o, new_pc_o, e.stall, e.flush, e.pc); end
      n_cmp++; if ({stall_cycles_o, flush_count_o, stall_timeout_o} !== {m_cycles, m_flushes, m_to}) begin n_err++;
        $display("FAIL deferred_cnt cyc%0d: got %0d/%0d/%b want %0d/%0d/%b", cyc, stall_cycles_o, flush_count_o, stall_timeout_o, m_cycles, m_flushes, m_to); end
      model_edge(e);
    end
  endtask

  task automatic test_watchdog();
    for (int k = 0; k < 11; k++) begin
      if (k < 8) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'b000011, 1'b0, 32'h0);
      else       drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0);
      @(negedge clk); e = sb_q.pop_front();
      n_cmp++; if ({stall_o, flush_o, new_pc_o} !== {e.stall, e.flush, e.pc}) begin n_err++;
        $display("FAIL wdog_out cyc%0d: got %b/%b/%h want %b/%b/%h", cyc, stall_o, flush_o, new_pc_o, e.stall, e.flush, e.pc); end
      n_cmp++; if ({stall_cycles_o, flush_count_o, stall_timeout_o} !== {m_cycles, m_flushes, m_to}) begin n_err++;
        $display("FAIL wdog_cnt cyc%0d: got %0d/%0d/%b want %0d/%0d/%b", cyc, stall_cycles_o, flush_count_o, stall_timeout_o, m_cycles, m_flushes, m_to); end
      model_edge(e);
    end
    @(negedge clk);
    n_cmp++; if (stall_timeout_o !== 1'b1) begin n_err++;
      $display("FAIL wdog_sticky cyc%0d: got %b want 1", cyc, stall_timeout_o); end
    @(posedge clk); #1; cyc++;
  endtask

  task automatic test_reset_in_pend();
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1, 32'h0, 6'b011111, 1'b0, 32'h0);
        1: drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0);
        2: drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0);
        3: drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h0);
        default: drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0);
      endcase
      @(negedge clk); e = sb_q.pop_front();
      n_cmp++; if ({stall_o, flush_o, new_pc_o} !== {e.stall, e.flush, e.pc}) begin n_err++;
        $display("FAIL rst_pend cyc%0d: got %b/%b/%h want %b/%b/%h", cyc, stall_o, flush_o, new_pc_o, e.stall, e.flush, e.pc); end
      n_cmp++; if ({stall_cycles_o, flush_count_o, stall_timeout_o} !== {m_cycles, m_flushes, m_to}) begin n_err++;
        $display("FAIL rst_pend_cnt cyc%0d: got %0d/%0d/%b want %0d/%0d/%b", cyc, stall_cycles_o, flush_count_o, stall_timeout_o, m_cycles, m_flushes, m_to); end
      model_edge(e);
    end
  endtask

  initial begin
    test_reset();
    test_stall_priority();
    test_flush();
    test_deferred_exc();
    test_watchdog();
    test_reset_in_pend();
    n_cmp++; if (sb_q.size() != 0) begin n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
